// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating up-counter. Clear wins over start (load), and start wins over
// increment. done is high while the count sits at LIMIT.
module mem_arb_timer #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         start,
    input  logic [W-1:0] start_val,
    input  logic         inc,
    output logic         done
);

    localparam logic [W-1:0] LIM_V = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear, load, or saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (start) begin
            cnt_d = start_val;
        end else if (inc && (cnt_q != LIM_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LIM_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle req/ack memory between instruction fetch and the
// load/store stage. Data has priority; fetch is guaranteed a grant after
// STARVE_LIM consecutive data grants; each access aborts after TIMEOUT cycles.
//
//   state  | meaning
//   IDLE   | no access in flight; arbitrate pending requests
//   BUSY_D | data access on the bus, waiting for mem_ack or timeout
//   BUSY_I | fetch access on the bus, waiting for mem_ack or timeout
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_d
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIM + 1);

    state_e              state_q,     state_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q,    mem_be_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic                if_valid_q,  if_valid_d;
    logic                if_err_q,    if_err_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
    logic                d_valid_q,   d_valid_d;
    logic                d_err_q,     d_err_d;

    grant_e sel;
    grant_e gnt;
    logic   tmo_start, tmo_inc, tmo_done;
    logic   stv_clr, stv_inc, stv_done;

    // The timeout count is the number of cycles mem_req has been high,
    // including the current one, so it is loaded with 1 on grant.
    mem_arb_timer #(.LIMIT(TIMEOUT), .W(TMO_W)) u_tmo (
        .clk       (clk),
        .rst_n     (rst),
        .clr       (1'b0),
        .start     (tmo_start),
        .start_val (TMO_W'(1)),
        .inc       (tmo_inc),
        .done      (tmo_done)
    );

    mem_arb_timer #(.LIMIT(STARVE_LIM), .W(STV_W)) u_starve (
        .clk       (clk),
        .rst_n     (rst),
        .clr       (stv_clr),
        .start     (1'b0),
        .start_val ('0),
        .inc       (stv_inc),
        .done      (stv_done)
    );

    // arbitration, command latch and completion handling
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = 1'b0;
        if_err_d    = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        sel         = GNT_NONE;
        gnt         = GNT_NONE;
        tmo_start   = 1'b0;
        tmo_inc     = 1'b0;
        stv_clr     = 1'b0;
        stv_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && !(stv_done && if_req)) begin
                    sel = GNT_D;
                end else if (if_req) begin
                    sel = GNT_I;
                end
                // The winner is held off (nobody granted) while its own valid
                // is high, so the requester can retire the finished access.
                gnt = sel;
                if ((sel == GNT_D && d_valid_q) || (sel == GNT_I && if_valid_q)) begin
                    gnt = GNT_NONE;
                end

                stv_clr   = (gnt == GNT_I) || !if_req;
                stv_inc   = (gnt == GNT_D) && if_req;
                tmo_start = (gnt != GNT_NONE);

                if (gnt == GNT_D) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                end else if (gnt == GNT_I) begin
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                end
            end

            BUSY_D, BUSY_I: begin
                tmo_inc = 1'b1;
                // ack takes precedence over a coincident timeout
                if (mem_ack || tmo_done) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_D) begin
                        d_valid_d = 1'b1;
                        d_err_d   = !mem_ack;
                        d_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
                    end else begin
                        if_valid_d = 1'b1;
                        if_err_d   = !mem_ack;
                        if_rdata_d = mem_ack ? mem_rdata : '0;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            d_rdata_q   <= '0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            if_err_q    <= if_err_d;
            d_rdata_q   <= d_rdata_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign if_err    = if_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;

    assign stall_if = if_req & ~if_valid_q;
    assign stall_d  = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single accesses plus
// hand-written collision, starvation, timeout and reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid, if_err;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_valid, d_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_if, stall_d;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_d(stall_d)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          n_ack;
        logic [31:0] rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[5];

    // One access: request at cycle 0, mem_req at 1, ack at 1+N, valid at 2+N.
    task automatic run_vec(input vec_t v);
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        e_wd = v.is_d ? v.wdata : 32'h0;
        e_be = v.is_d ? v.be : 4'hF;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        chk("stall_c0", v.is_d ? stall_d : stall_if, 1'b1);
        @(negedge clk);
        chk("mem_req_c1", mem_req, 1'b1);
        chk("mem_we", mem_we, v.is_d ? v.we : 1'b0);
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("mem_be", mem_be, e_be);
        for (int i = 0; i < v.n_ack; i++) begin
            @(negedge clk);
            chk("mem_req_hold", mem_req, 1'b1);
            chk("mem_wdata_hold", mem_wdata, e_wd);
            chk("mem_be_hold", mem_be, e_be);
            chk("stall_hold", v.is_d ? stall_d : stall_if, 1'b1);
        end
        mem_ack = 1'b1; mem_rdata = v.rd;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("valid", v.is_d ? d_valid : if_valid, 1'b1);
        chk("other_valid", v.is_d ? if_valid : d_valid, 1'b0);
        chk("err", v.is_d ? d_err : if_err, 1'b0);
        chk("rdata", v.is_d ? d_rdata : if_rdata, v.exp_rd);
        chk("mem_req_drop", mem_req, 1'b0);
        chk("stall_at_valid", v.is_d ? stall_d : stall_if, 1'b0);
        if (v.is_d) d_req = 1'b0; else if_req = 1'b0;
        @(negedge clk);
        chk("valid_pulse", v.is_d ? d_valid : if_valid, 1'b0);
    endtask

    initial begin
        int hi;
        int w;
        logic is_dgnt;
        vec_t v;

        vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         4'hF, 3, 32'h0050_0093, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b0, 32'h8000_1000, 32'h0,         4'hF, 0, 32'h1234_5678, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h8000_2000, 32'hDEAD_BEEF, 4'h3, 2, 32'hFFFF_FFFF, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0,         4'hF, 1, 32'h00A0_0113, 32'h00A0_0113};
        vecs[4] = '{1'b1, 1'b0, 32'h8000_2004, 32'h0,         4'h8, 5, 32'hCAFE_F00D, 32'hCAFE_F00D};

        rst = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        // reset state
        #12;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", mem_be, 4'h0);
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_d_valid", d_valid, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_errs", {if_err, d_err}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // table of single accesses
        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // collision: data first, fetch only after d_valid
        if_req = 1'b1; if_addr = 32'h8000_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_1000; d_be = 4'hF; d_wdata = 32'h0;
        #1;
        chk("col_stall_if_c0", stall_if, 1'b1);
        @(negedge clk);
        chk("col_first_addr", mem_addr, 32'h8000_1000);
        chk("col_first_req", mem_req, 1'b1);
        chk("col_stall_if_c1", stall_if, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("col_d_valid", d_valid, 1'b1);
        chk("col_d_rdata", d_rdata, 32'h1111_2222);
        chk("col_if_valid_c2", if_valid, 1'b0);
        chk("col_mem_req_c2", mem_req, 1'b0);
        chk("col_stall_if_c2", stall_if, 1'b1);
        d_req = 1'b0;
        @(negedge clk);
        chk("col_second_req", mem_req, 1'b1);
        chk("col_second_addr", mem_addr, 32'h8000_0100);
        chk("col_stall_if_c3", stall_if, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("col_if_valid", if_valid, 1'b1);
        chk("col_if_rdata", if_rdata, 32'h0000_0013);
        if_req = 1'b0;
        @(negedge clk);

        // starvation: stores held continuously with fetch pending
        if_req = 1'b1; if_addr = 32'h8000_0200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_3000; d_wdata = 32'h5555_AAAA; d_be = 4'hF;
        for (int g = 0; g < 6; g++) begin
            w = 0;
            while (!mem_req && w < 10) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("starve_wait%0d", g), (w < 10), 1'b1);
            is_dgnt = (mem_addr == 32'h8000_3000);
            chk($sformatf("starve_grant%0d_is_data", g), is_dgnt, (g == 4) ? 1'b0 : 1'b1);
            mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
            @(negedge clk);
            mem_ack = 1'b0;
            chk($sformatf("starve_valid%0d", g), is_dgnt ? d_valid : if_valid, 1'b1);
            if (is_dgnt) chk($sformatf("starve_store_rdata%0d", g), d_rdata, 32'h0);
            if (g == 4) if_req = 1'b0;
            if (g == 5) d_req = 1'b0;
        end
        @(negedge clk);

        // timeout: load never acked
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_4000; d_be = 4'hF;
        @(negedge clk);
        hi = 0;
        while (mem_req && hi < 400) begin
            hi++;
            @(negedge clk);
        end
        chk("tmo_cycles_high", hi, 255);
        chk("tmo_d_valid", d_valid, 1'b1);
        chk("tmo_d_err", d_err, 1'b1);
        chk("tmo_d_rdata", d_rdata, 32'h0);
        d_req = 1'b0;
        @(negedge clk);
        chk("tmo_valid_pulse", d_valid, 1'b0);

        // ack in the same cycle the timeout expires: ack wins
        if_req = 1'b1; if_addr = 32'h8000_0400;
        @(negedge clk);
        chk("race_req_c1", mem_req, 1'b1);
        repeat (254) @(negedge clk);
        chk("race_req_c255", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("race_if_valid", if_valid, 1'b1);
        chk("race_if_err", if_err, 1'b0);
        chk("race_if_rdata", if_rdata, 32'hA5A5_0001);
        if_req = 1'b0;
        @(negedge clk);

        // reset mid-access, then a late ack
        if_req = 1'b1; if_addr = 32'h8000_0300;
        @(negedge clk);
        chk("rma_req_c1", mem_req, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b0; if_req = 1'b0;
        #1;
        chk("rma_req_async_drop", mem_req, 1'b0);
        chk("rma_if_valid", if_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rma_late_ack_valid", if_valid, 1'b0);
        chk("rma_late_ack_req", mem_req, 1'b0);
        @(negedge clk);
        chk("rma_late_ack_valid2", if_valid, 1'b0);
        chk("rma_if_rdata", if_rdata, 32'h0);
        v = '{1'b1, 1'b0, 32'h8000_5000, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 32'h0BAD_F00D};
        run_vec(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, multi-cycle memory between the instruction-fetch stage and the memory stage (load/store) of the 5-stage pipeline.
- Serialises requests onto a req/ack memory bus and returns read data with valid pulses.
- Generates stall signals that the hazard logic ORs into the pipeline STALL.
- Data accesses have priority, with bounded fetch starvation and a per-access timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- STARVE_LIM, 4, maximum consecutive data grants while if_req is pending.
- TIMEOUT, 255, maximum cycles mem_req is held without mem_ack before an error abort.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held with if_addr until if_valid.
- if_addr  input  ADDR_W  fetch address.
- if_rdata  output  DATA_W  fetched instruction, registered.
- if_valid  output  1  one-cycle pulse: if_rdata valid / fetch done.
- if_err  output  1  qualifies if_valid: access timed out.
- d_req  input  1  data request; held with all d_* inputs until d_valid.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_be  input  DATA_W/8  byte enables.
- d_rdata  output  DATA_W  load data, registered; 0 after a store.
- d_valid  output  1  one-cycle pulse: data access done.
- d_err  output  1  qualifies d_valid: access timed out.
- mem_req  output  1  memory request, registered.
- mem_we, mem_addr, mem_wdata, mem_be  output  1/ADDR_W/DATA_W/DATA_W/8  registered memory command.
- mem_ack  input  1  memory completion; only sampled while mem_req=1.
- mem_rdata  input  DATA_W  read data, valid with mem_ack.
- stall_if  output  1  combinational: if_req & ~if_valid.
- stall_d  output  1  combinational: d_req & ~d_valid.

Behaviour:
- Reset (async, rst=0):
  - State goes to IDLE; mem_req and all mem_* outputs go to 0.
  - All *_rdata, *_valid and *_err outputs go to 0.
  - The starvation counter and the timeout counter clear to 0.
  - If reset asserts mid-access, mem_req drops immediately and no valid is produced; an ack arriving after reset releases is ignored.
- State machine:
  - IDLE:
    - Requests are arbitrated only in IDLE.
    - A request is ignored in the cycle its own valid is high, so the requester can retire it.
    - Grant goes to data if d_req, unless starve_cnt == STARVE_LIM and if_req; otherwise grant goes to fetch if if_req.
    - On grant, the command is latched into mem_*, mem_req is set next cycle, and the state moves to BUSY_D or BUSY_I.
  - BUSY_D / BUSY_I:
    - mem_req and the command are held stable; tmo_cnt increments each cycle.
    - When mem_ack=1: mem_rdata is captured (BUSY_I into if_rdata; BUSY_D into d_rdata, or 0 for a store), mem_req drops, the matching valid pulses next cycle with err=0, and the state returns to IDLE.
    - When tmo_cnt == TIMEOUT and mem_ack=0: mem_req drops, the matching valid pulses with err=1, rdata is set to 0, and the state returns to IDLE.
    - If mem_ack and the timeout coincide, the ack wins.
- Latency:
  - A request sampled in IDLE at cycle 0 gives mem_req=1 at cycle 1.
  - With mem_ack at cycle 1+N, valid is asserted at cycle 2+N.
  - Minimum 2 cycles; back-to-back issue is possible with 1 IDLE cycle between accesses.
- Starvation counter:
  - Increments on a data grant while if_req=1, saturating at STARVE_LIM.
  - Clears on any fetch grant, or when if_req=0 in IDLE.
- Counter widths: counters are sized by $clog2(param+1); no wrap is possible because both counters saturate or clear.
- Simultaneous if_req and d_req in IDLE: data wins, subject to the starvation rule above.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BUSY_D, BUSY_I) and a grant_e enum (GNT_NONE, GNT_I, GNT_D).
- One sub-module: mem_arb_timer, a loadable saturating counter with clear, start and done outputs. It is instantiated twice: once for timeout, once for starvation.
- Remaining logic stays in mem_port_arbiter.

Test Plan:
- Fetch only:
  - Stimulus: if_req=1, if_addr=0x80000000; memory acks after 3 cycles with 0x00500093.
  - Response: mem_req high for cycles 1–4, if_valid at cycle 5, if_rdata=0x00500093, stall_if high for cycles 0–4.
- Collision:
  - Stimulus: if_req and d_req (load 0x80001000) both asserted at cycle 0.
  - Response: the data access is issued first; the fetch is issued only after d_valid; stall_if stays high throughout.
- Starvation:
  - Stimulus: d_req held continuously (5 back-to-back stores) with if_req held.
  - Response: the 5th grant goes to fetch, i.e. after 4 data grants (STARVE_LIM=4).
- Timeout:
  - Stimulus: d_req load issued; mem_ack is never asserted.
  - Response: mem_req drops after 255 cycles; d_valid=1, d_err=1, d_rdata=0 on the following cycle.
- Reset mid-access:
  - Stimulus: rst=0 during BUSY_I, then a late mem_ack arrives after reset releases.
  - Response: mem_req=0 asynchronously, no if_valid, state IDLE, next request arbitrates normally.
- Store:
  - Stimulus: d_we=1, d_be=0b0011, d_wdata=0xDEADBEEF.
  - Response: mem_be=0b0011 and mem_wdata=0xDEADBEEF held stable until ack; d_rdata=0.
